simon_core_ed: RTL
==================

SIMON_CORE_ED -- requirements
Module: simon_core_ed

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N, 16, word width in bits; block is 2N bits.
- M, 4, key words, legal values 2, 3 or 4.
- T, 32, round count.
- Cb, 5, counter width; SHALL satisfy 2^Cb >= T.
- Z, 62'b01100111000011010100100010111110110011100001101010010001011111, z-sequence; bit i is used at key step i mod 62.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock; all state changes on the rising edge.
- nR, in, 1, reset; asynchronous, active-low.
- newData, in, 1, start request; sampled only in IDLE.
- newKey, in, 1, reload and expand key; qualified by newData.
- decrypt, in, 1, 1 = decrypt, 0 = encrypt; captured with newData.
- readData, in, 1, consumer has taken cipher.
- plain, in, 2N, input block {x, y}, x = upper word.
- key, in, M x N, key words; key[0] is the first round key.
- busy, out, 1, high in KEY and RUN.
- keyValid, out, 1, round-key store holds a complete expansion.
- doneData, out, 1, cipher valid.
- cipher, out, 2N, result block {x, y}.

Function
REQ-003 States SHALL be IDLE, KEY, RUN and DONE; state and counter SHALL be registered.
REQ-004 IDLE, newData=1 SHALL:
- capture plain and decrypt;
- set count to 0;
- go to KEY if newKey=1 or keyValid=0, otherwise go to RUN.
REQ-005 KEY SHALL take exactly T cycles and write round key i (i = 0..T-1) into an internal T x N store, as follows:
- k[i] = key[i] for i < M;
- otherwise k[i] = ~k[i-M] ^ tmp ^ (tmp>>>1) ^ Z[(i-M) mod 62] ^ 3;
- tmp = k[i-1]>>>3, with k[i-3] additionally XORed into tmp when M=4;
- >>> is rotate right within N bits.
REQ-006 On leaving KEY, keyValid SHALL be 1, count SHALL be 0, and the next state SHALL be RUN.
REQ-007 RUN SHALL take exactly T cycles, one round per cycle, with f(w) = (w<<<1 & w<<<8) ^ (w<<<2).
- Encrypt applies round key index count: (x, y) -> (y ^ f(x) ^ k, x).
- Decrypt applies round key index T-1-count: (x, y) -> (y, x ^ f(y) ^ k).
REQ-008 On the final RUN edge, the round result SHALL load into cipher, doneData SHALL go to 1, and the state SHALL go to DONE.
REQ-009 Latency, counted in rising edges after the newData sampling edge, SHALL be T with a cached key and 2T with expansion.
REQ-010 DONE SHALL hold cipher and doneData stable until readData=1; on that edge doneData SHALL clear and the state SHALL go to IDLE, with cipher retained.
REQ-011 Inputs received outside IDLE SHALL be handled as follows:
- newData, newKey and decrypt asserted in KEY, RUN or DONE SHALL be ignored;
- key and plain SHALL be ignored outside the capture and KEY cycles;
- key SHALL be held stable by the source during KEY.
REQ-012 newData together with readData in DONE SHALL return the block to IDLE only; the request SHALL NOT be captured.
REQ-013 newKey without newData SHALL have no effect.
REQ-014 count SHALL never exceed T-1 and SHALL NOT wrap within a state.
REQ-015 busy SHALL be a decode of the state (KEY or RUN) with no extra latency.

Reset
REQ-016 nR=0 SHALL immediately clear the following, regardless of state:
- state to IDLE;
- count, busy, keyValid, doneData and cipher to 0;
- key store and data registers to 0.
REQ-017 An operation interrupted by reset SHALL be lost, and keyValid SHALL stay 0 until a full KEY pass completes.
REQ-018 Leaving reset, the block SHALL act on newData at the first rising edge after nR rises.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Encrypt with expansion, N=16 M=4 T=32, key {0x1918, 0x1110, 0x0908, 0x0100} (key[3]..key[0]), plain 0x65656877, newKey=1 -> cipher 0xc69be9bb; doneData rises 64 edges after the start; keyValid=1.
- Decrypt with cached key, plain 0xc69be9bb, decrypt=1, newKey=0 -> cipher 0x65656877; doneData rises 32 edges after the start.
- newData pulsed during RUN and during DONE without readData -> ignored; cipher is unchanged and no second result appears.
- nR pulsed low at RUN cycle 10 -> all outputs 0 and keyValid=0; the next newData with newKey=0 still passes through KEY (64-edge latency).
- newData and readData high together in DONE -> IDLE with doneData=0 and no new run; a later newData starts normally.
- Back-to-back encrypts of 0x65656877 with newKey=0 -> both return 0xc69be9bb with 32-edge latency, and busy is high for exactly 32 cycles each.

Source files
------------

// File: rtl/simon_core_ed.sv
// Iterative SIMON block cipher core: one round per clock, with an on-chip round-key
// store that is filled by a key-expansion pass and reused by later blocks.
module simon_core_ed #(
   parameter int unsigned N  = 16,
   parameter int unsigned M  = 4,
   parameter int unsigned T  = 32,
   parameter int unsigned Cb = 5,
   parameter logic [61:0] Z  = 62'b01100111000011010100100010111110110011100001101010010001011111
) (
   input  logic                   clk,
   input  logic                   nR,
   input  logic                   newData,
   input  logic                   newKey,
   input  logic                   decrypt,
   input  logic                   readData,
   input  logic [2*N-1:0]         plain,
   input  logic [M-1:0][N-1:0]    key,
   output logic                   busy,
   output logic                   keyValid,
   output logic                   doneData,
   output logic [2*N-1:0]         cipher
);

   typedef enum logic [1:0] {StIdle, StKey, StRun, StDone} state_e;

   state_e         state_q, state_d;
   logic [Cb-1:0]  count_q, count_d;
   logic [5:0]     z_idx_q, z_idx_d;
   logic           kv_q, kv_d;
   logic           done_q, done_d;
   logic           dec_q, dec_d;
   logic [N-1:0]   x_q, x_d, y_q, y_d;
   logic [2*N-1:0] cipher_q, cipher_d;
   logic [N-1:0]   ks_q [T];
   logic           ks_we;
   logic [N-1:0]   ks_wdata;

   // Key-expansion and round datapath temporaries.
   logic [Cb-1:0]  i1, i3, im;
   logic [N-1:0]   kw, tmp, knew, rk, nx, ny;

   function automatic logic [N-1:0] rotl(input logic [N-1:0] w, input int unsigned s);
      return (w << s) | (w >> (N - s));
   endfunction

   function automatic logic [N-1:0] rotr(input logic [N-1:0] w, input int unsigned s);
      return (w >> s) | (w << (N - s));
   endfunction

   function automatic logic [N-1:0] fround(input logic [N-1:0] w);
      return (rotl(w, 1) & rotl(w, 8)) ^ rotl(w, 2);
   endfunction

   // Next-state, key-expansion and round logic.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      z_idx_d  = z_idx_q;
      kv_d     = kv_q;
      done_d   = done_q;
      dec_d    = dec_q;
      x_d      = x_q;
      y_d      = y_q;
      cipher_d = cipher_q;
      ks_we    = 1'b0;
      ks_wdata = '0;

      // Expansion term for round key count_q (only meaningful once count_q >= M).
      i1  = count_q - Cb'(1);
      i3  = count_q - Cb'(3);
      im  = count_q - Cb'(M);
      tmp = rotr(ks_q[i1], 3);
      if (M == 4) tmp = tmp ^ ks_q[i3];
      knew = ~ks_q[im] ^ tmp ^ rotr(tmp, 1) ^ {{(N-1){1'b0}}, Z[z_idx_q]} ^ N'(3);

      kw = '0;
      for (int unsigned j = 0; j < M; j++) begin
         if (count_q == Cb'(j)) kw = key[j];
      end

      // Decrypt walks the key store backwards.
      rk = dec_q ? ks_q[Cb'(T-1) - count_q] : ks_q[count_q];
      if (dec_q) begin
         nx = y_q;
         ny = x_q ^ fround(y_q) ^ rk;
      end else begin
         nx = y_q ^ fround(x_q) ^ rk;
         ny = x_q;
      end

      unique case (state_q)
         StIdle: begin
            if (newData) begin
               x_d     = plain[2*N-1:N];
               y_d     = plain[N-1:0];
               dec_d   = decrypt;
               count_d = '0;
               if (newKey || !kv_q) begin
                  state_d = StKey;
                  kv_d    = 1'b0;  // store is about to be partially overwritten
                  z_idx_d = '0;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StKey: begin
            ks_we    = 1'b1;
            ks_wdata = (count_q < Cb'(M)) ? kw : knew;
            if (count_q >= Cb'(M)) z_idx_d = (z_idx_q == 6'd61) ? 6'd0 : z_idx_q + 6'd1;
            if (count_q == Cb'(T-1)) begin
               count_d = '0;
               kv_d    = 1'b1;
               state_d = StRun;
            end else begin
               count_d = count_q + Cb'(1);
            end
         end
         StRun: begin
            x_d = nx;
            y_d = ny;
            if (count_q == Cb'(T-1)) begin
               cipher_d = {nx, ny};
               done_d   = 1'b1;
               count_d  = '0;
               state_d  = StDone;
            end else begin
               count_d = count_q + Cb'(1);
            end
         end
         StDone: begin
            if (readData) begin
               done_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control and data registers.
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         state_q  <= StIdle;
         count_q  <= '0;
         z_idx_q  <= '0;
         kv_q     <= 1'b0;
         done_q   <= 1'b0;
         dec_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         cipher_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         z_idx_q  <= z_idx_d;
         kv_q     <= kv_d;
         done_q   <= done_d;
         dec_q    <= dec_d;
         x_q      <= x_d;
         y_q      <= y_d;
         cipher_q <= cipher_d;
      end
   end

   // Round-key store, written one word per KEY cycle.
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         for (int i = 0; i < T; i++) ks_q[i] <= '0;
      end else if (ks_we) begin
         ks_q[count_q] <= ks_wdata;
      end
   end

   assign busy     = (state_q == StKey) || (state_q == StRun);
   assign keyValid = kv_q;
   assign doneData = done_q;
   assign cipher   = cipher_q;

endmodule
